memoria_control: RTL

- Microprogram control store, mapping table, interrupt-vector logic and pipeline register, sitting directly downstream of the microprogram sequencer.
- Consumes the sequencer's 4-bit `estado_presente` address and its `pl`, `map_hab` and `vect_hab` strobes.
- Produces the sequencer inputs `microinstruccion`, `liga`, `cc`, `vmap` and `vect`, plus the datapath control bits.
- Control store and mapping table are writable through a load port, so microcode can be loaded at run time.

---
 rtl/memoria_control_if.sv | 40 ++++
 rtl/memoria_control.sv | 96 +++++++++
 2 files changed

// File: rtl/memoria_control_if.sv
// Sequencer-facing and load-port signals of the microprogram control store.
// master drives the store's inputs (sequencer/loader side); slave is the store.
interface memoria_control_if #(parameter int ANCHO_CTRL = 7) ();
  logic [3:0]            estado_presente;
  logic                  pl;
  logic                  map_hab;
  logic                  vect_hab;
  logic [1:0]            microinstruccion;
  logic [3:0]            liga;
  logic                  cc;
  logic [3:0]            vmap;
  logic [3:0]            vect;
  logic [ANCHO_CTRL-1:0] control;
  logic                  bandera_z;
  logic                  bandera_c;
  logic [3:0]            opcode;
  logic                  opcode_valido;
  logic                  opcode_acepta;
  logic                  opcode_lleno;
  logic [3:0]            irq;
  logic [3:0]            mascara;
  logic                  int_pend;
  logic                  escribe;
  logic [4:0]            dir_esc;
  logic [15:0]           dato_esc;

  modport master (
    output estado_presente, pl, map_hab, vect_hab, bandera_z, bandera_c,
           opcode, opcode_valido, irq, mascara, escribe, dir_esc, dato_esc,
    input  microinstruccion, liga, cc, vmap, vect, control,
           opcode_acepta, opcode_lleno, int_pend
  );

  modport slave (
    input  estado_presente, pl, map_hab, vect_hab, bandera_z, bandera_c,
           opcode, opcode_valido, irq, mascara, escribe, dir_esc, dato_esc,
    output microinstruccion, liga, cc, vmap, vect, control,
           opcode_acepta, opcode_lleno, int_pend
  );
endinterface

// File: rtl/memoria_control.sv
// Writable control store + mapping table, microword pipeline register,
// opcode holding register and prioritised interrupt vector generation.
module memoria_control #(
    parameter int         ANCHO_CTRL = 7,
    parameter logic [3:0] BASE_VECT  = 4'b1100
) (
    input  logic              reloj,
    input  logic              reset,
    memoria_control_if.slave  bus
);
    localparam int ANCHO_PAL = 9 + ANCHO_CTRL;

    logic [ANCHO_PAL-1:0] cs_q  [16];
    logic [3:0]           map_q [16];

    logic [ANCHO_PAL-1:0] pipe_q, pipe_d;
    logic [3:0]           op_q, op_d;
    logic                 lleno_q, lleno_d;
    logic [3:0]           pend_q, pend_d;

    logic [3:0] visible;
    logic [1:0] idx;
    logic       acepta;
    logic       cond_raw;
    logic       unused_pl;

    assign unused_pl = bus.pl;

    // Storage is not reset; a write while reset is low is discarded.
    always_ff @(posedge reloj) begin
        if (reset && bus.escribe) begin
            if (bus.dir_esc[4])
                map_q[bus.dir_esc[3:0]] <= bus.dato_esc[3:0];
            else
                cs_q[bus.dir_esc[3:0]] <= bus.dato_esc[ANCHO_PAL-1:0];
        end
    end

    always_comb begin
        pipe_d = cs_q[bus.estado_presente];

        acepta  = bus.opcode_valido & (~lleno_q | ~bus.map_hab);
        op_d    = op_q;
        lleno_d = lleno_q;
        if (acepta) begin
            op_d    = bus.opcode;
            lleno_d = 1'b1;
        end else if (!bus.map_hab) begin
            lleno_d = 1'b0;
        end

        visible = pend_q & bus.mascara;
        idx     = 2'd0;
        for (int i = 0; i < 4; i++)
            if (visible[i]) idx = i[1:0];

        // Clear of the vectored bit takes priority over a fresh request on it.
        pend_d = pend_q | (bus.irq & bus.mascara);
        if (!bus.vect_hab && (|visible))
            pend_d[idx] = 1'b0;
    end

    always_ff @(posedge reloj or negedge reset) begin
        if (!reset) begin
            pipe_q  <= '0;
            op_q    <= '0;
            lleno_q <= 1'b0;
            pend_q  <= '0;
        end else begin
            pipe_q  <= pipe_d;
            op_q    <= op_d;
            lleno_q <= lleno_d;
            pend_q  <= pend_d;
        end
    end

    always_comb begin
        unique case (pipe_q[7:6])
            2'b00:   cond_raw = 1'b1;
            2'b01:   cond_raw = bus.bandera_z;
            2'b10:   cond_raw = bus.bandera_c;
            default: cond_raw = ~(|visible);
        endcase
    end

    assign bus.microinstruccion = pipe_q[1:0];
    assign bus.liga             = pipe_q[5:2];
    assign bus.control          = pipe_q[ANCHO_PAL-1:9];
    assign bus.cc               = cond_raw ^ pipe_q[8];
    assign bus.opcode_acepta    = acepta;
    assign bus.opcode_lleno     = lleno_q;
    assign bus.vmap             = lleno_q ? map_q[op_q] : 4'd0;
    assign bus.int_pend         = |visible;
    assign bus.vect             = BASE_VECT | {2'b00, idx};

endmodule
